// File: rtl/sap_pkg.sv
// sap_pkg: shared widths, program-region bound and store FSM states for the SAP-1 datapath
package sap_pkg;
    localparam int SAP_ADDR_W   = 4;
    localparam int SAP_DATA_W   = 8;
    localparam int SAP_PROG_TOP = 7;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_WRITE,
        ST_READ,
        ST_CHECK,
        ST_DONE
    } store_state_t;
endpackage

// File: rtl/sap_store_unit.sv
// sap_store_unit: sequences one store through MAR and RAM write port, with optional read-back verify
module sap_store_unit
    import sap_pkg::*;
#(
    parameter int ADDR_W   = SAP_ADDR_W,
    parameter int DATA_W   = SAP_DATA_W,
    parameter bit VERIFY   = 1'b1,
    parameter int PROG_TOP = SAP_PROG_TOP
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              st_valid,
    output logic              st_ready,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    input  logic              wp,
    output logic              Lm,
    output logic [ADDR_W-1:0] mar_addr,
    output logic              We,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              Ce,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam logic [ADDR_W-1:0] TOP = ADDR_W'(PROG_TOP);

    store_state_t      state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              err_q, err_d;
    logic              accept, refuse;

    assign accept = st_valid && state_q == ST_IDLE;
    // wp is only consulted at acceptance, so the refusal decision is taken from the live inputs
    assign refuse = wp && st_addr <= TOP;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  state_d = !st_valid ? ST_IDLE : refuse ? ST_DONE : ST_ADDR;
            ST_ADDR:  state_d = ST_WRITE;
            ST_WRITE: state_d = VERIFY ? ST_READ : ST_DONE;
            ST_READ:  state_d = ST_CHECK;
            ST_CHECK: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        addr_d = accept ? st_addr : addr_q;
        data_d = accept ? st_data : data_q;
        err_d  = accept ? refuse : (state_q == ST_CHECK && ram_rdata != data_q) ? 1'b1 : err_q;
    end

    always_comb begin
        st_ready  = state_q == ST_IDLE;
        busy      = state_q != ST_IDLE;
        Lm        = state_q == ST_ADDR;
        We        = state_q == ST_WRITE;
        Ce        = state_q == ST_READ;
        done      = state_q == ST_DONE;
        err       = err_q;
        mar_addr  = addr_q;
        ram_wdata = data_q;
    end
endmodule

// File: tb/tb_sap_store_unit.sv
// tb_sap_store_unit: directed and randomized checks of the store sequencer against a RAM model
module tb_sap_store_unit;
    import sap_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, valid_v, valid_n, wp, force_zero;
    logic [3:0] st_addr;
    logic [7:0] st_data;
    logic       rdy_v, lm_v, we_v, ce_v, busy_v, done_v, err_v;
    logic       rdy_n, lm_n, we_n, ce_n, busy_n, done_n, err_n;
    logic [3:0] ma_v, ma_n, mar_v, mar_n;
    logic [7:0] wd_v, wd_n, rd_v, rd_n;
    logic [7:0] mem_v [16];
    logic [7:0] mem_n [16];

    sap_store_unit #(.VERIFY(1'b1)) dut_v (
        .clk(clk), .reset(reset), .st_valid(valid_v), .st_ready(rdy_v),
        .st_addr(st_addr), .st_data(st_data), .wp(wp), .Lm(lm_v), .mar_addr(ma_v),
        .We(we_v), .ram_wdata(wd_v), .Ce(ce_v), .ram_rdata(rd_v),
        .busy(busy_v), .done(done_v), .err(err_v)
    );

    sap_store_unit #(.VERIFY(1'b0)) dut_n (
        .clk(clk), .reset(reset), .st_valid(valid_n), .st_ready(rdy_n),
        .st_addr(st_addr), .st_data(st_data), .wp(wp), .Lm(lm_n), .mar_addr(ma_n),
        .We(we_n), .ram_wdata(wd_n), .Ce(ce_n), .ram_rdata(rd_n),
        .busy(busy_n), .done(done_n), .err(err_n)
    );

    // MAR register plus RAM with registered read; force_zero corrupts read-back data
    always @(posedge clk) begin
        if (lm_v) mar_v <= ma_v;
        if (we_v) mem_v[mar_v] <= wd_v;
        if (ce_v) rd_v <= force_zero ? 8'h00 : mem_v[mar_v];
        if (lm_n) mar_n <= ma_n;
        if (we_n) mem_n[mar_n] <= wd_n;
        if (ce_n) rd_n <= force_zero ? 8'h00 : mem_n[mar_n];
    end

    int ncmp, nfail;
    int lat, nlm, nwe, nce, f_lm, f_we, f_ce, nd, na, exp_lat;
    int acc_t [2];
    logic e_done, e1, refused, exp_err;
    logic [3:0] ma_at, ra;
    logic [7:0] wd_at, rd;
    logic rv, rw, rc;
    logic [7:0] sh_v [16];
    logic [7:0] sh_n [16];
    logic ok_v [16];
    logic ok_n [16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_store(input logic v, input logic [3:0] a, input logic [7:0] d, input logic w);
        @(negedge clk);
        st_addr = a;
        st_data = d;
        wp = w;
        if (v) valid_v = 1'b1; else valid_n = 1'b1;
        lat = -1; nlm = 0; nwe = 0; nce = 0; f_lm = -1; f_we = -1; f_ce = -1;
        e_done = 1'b0; e1 = 1'b0; ma_at = '0; wd_at = '0;
        for (int i = 1; i <= 20 && lat < 0; i++) begin
            @(negedge clk);
            valid_v = 1'b0;
            valid_n = 1'b0;
            if (v ? lm_v : lm_n) begin
                nlm++;
                if (f_lm < 0) begin f_lm = i; ma_at = v ? ma_v : ma_n; end
            end
            if (v ? we_v : we_n) begin
                nwe++;
                if (f_we < 0) begin f_we = i; wd_at = v ? wd_v : wd_n; end
            end
            if (v ? ce_v : ce_n) begin
                nce++;
                if (f_ce < 0) f_ce = i;
            end
            if (i == 1) e1 = v ? err_v : err_n;
            if (v ? done_v : done_n) begin lat = i; e_done = v ? err_v : err_n; end
        end
    endtask

    initial begin
        ncmp = 0; nfail = 0;
        reset = 1'b1; valid_v = 1'b0; valid_n = 1'b0; wp = 1'b0; force_zero = 1'b0;
        st_addr = '0; st_data = '0;
        for (int i = 0; i < 16; i++) begin ok_v[i] = 1'b0; ok_n[i] = 1'b0; sh_v[i] = '0; sh_n[i] = '0; end
        repeat (2) @(negedge clk);
        chk("rst_flags_v", 32'({rdy_v, lm_v, we_v, ce_v, busy_v, done_v, err_v}), 32'h40);
        chk("rst_flags_n", 32'({rdy_n, lm_n, we_n, ce_n, busy_n, done_n, err_n}), 32'h40);
        chk("rst_mar_v", 32'(ma_v), 32'h0);
        chk("rst_wdata_v", 32'(wd_v), 32'h0);
        reset = 1'b0;

        run_store(1'b1, 4'hA, 8'h3C, 1'b0);
        chk("v_lm_cycle", 32'(f_lm), 32'd1);
        chk("v_mar_addr", 32'(ma_at), 32'hA);
        chk("v_we_cycle", 32'(f_we), 32'd2);
        chk("v_wdata", 32'(wd_at), 32'h3C);
        chk("v_ce_cycle", 32'(f_ce), 32'd3);
        chk("v_done_lat", 32'(lat), 32'd5);
        chk("v_err", 32'(e_done), 32'd0);
        chk("v_ram", 32'(mem_v[4'hA]), 32'h3C);

        run_store(1'b1, 4'h3, 8'h5A, 1'b1);
        chk("wp_lat", 32'(lat), 32'd1);
        chk("wp_err", 32'(e_done), 32'd1);
        chk("wp_strobes", 32'(nlm + nwe + nce), 32'd0);

        run_store(1'b1, 4'h3, 8'h5A, 1'b0);
        chk("nowp_lat", 32'(lat), 32'd5);
        chk("nowp_err", 32'(e_done), 32'd0);
        chk("nowp_ram", 32'(mem_v[4'h3]), 32'h5A);

        force_zero = 1'b1;
        run_store(1'b1, 4'h9, 8'hFF, 1'b0);
        force_zero = 1'b0;
        chk("mis_err", 32'(e_done), 32'd1);
        repeat (3) @(negedge clk);
        chk("mis_sticky", 32'({err_v, busy_v}), 32'h2);
        run_store(1'b1, 4'h9, 8'hFF, 1'b0);
        chk("mis_clear_on_accept", 32'(e1), 32'd0);
        chk("mis_next_err", 32'(e_done), 32'd0);

        @(negedge clk);
        st_addr = 4'h5; st_data = 8'h11; wp = 1'b0; valid_n = 1'b1; na = 0;
        for (int i = 0; i < 30 && na < 2; i++) begin
            if (rdy_n) begin acc_t[na] = i; na++; end
            @(negedge clk);
            if (na == 1) begin st_addr = 4'h6; st_data = 8'h22; end
        end
        valid_n = 1'b0;
        chk("b2b_count", 32'(na), 32'd2);
        chk("b2b_spacing", 32'(acc_t[1] - acc_t[0]), 32'd4);
        repeat (5) @(negedge clk);
        chk("b2b_ram5", 32'(mem_n[4'h5]), 32'h11);
        chk("b2b_ram6", 32'(mem_n[4'h6]), 32'h22);

        @(negedge clk);
        st_addr = 4'hB; st_data = 8'h77; wp = 1'b0; valid_v = 1'b1;
        @(negedge clk);
        valid_v = 1'b0;
        @(negedge clk);
        chk("rw_in_write", 32'(we_v), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rw_idle", 32'({rdy_v, lm_v, we_v, ce_v, busy_v, done_v}), 32'h20);
        nd = 0;
        repeat (8) begin
            @(negedge clk);
            if (done_v) nd++;
        end
        chk("rw_no_done", 32'(nd), 32'd0);
        chk("rw_word_kept", 32'(mem_v[4'hB]), 32'h77);
        run_store(1'b1, 4'hC, 8'h12, 1'b0);
        chk("rw_after_lat", 32'(lat), 32'd5);
        chk("rw_after_ram", 32'(mem_v[4'hC]), 32'h12);

        for (int k = 0; k < 40; k++) begin
            rv = 1'($urandom_range(0, 1));
            ra = 4'($urandom_range(0, 15));
            rd = 8'($urandom);
            rw = 1'($urandom_range(0, 1));
            rc = rv && ($urandom_range(0, 3) == 0);
            force_zero = rc;
            run_store(rv, ra, rd, rw);
            force_zero = 1'b0;
            refused = rw && ra <= 4'd7;
            exp_lat = refused ? 1 : rv ? 5 : 3;
            exp_err = refused || (rc && rd != 8'h00);
            chk("rnd_lat", 32'(lat), 32'(exp_lat));
            chk("rnd_err", 32'(e_done), 32'(exp_err));
            chk("rnd_strobes", 32'(nlm + nwe + nce), refused ? 32'd0 : rv ? 32'd3 : 32'd2);
            if (!refused) begin
                if (rv) begin sh_v[ra] = rd; ok_v[ra] = 1'b1; end
                else begin sh_n[ra] = rd; ok_n[ra] = 1'b1; end
            end
            if (rv ? ok_v[ra] : ok_n[ra])
                chk("rnd_ram", 32'(rv ? mem_v[ra] : mem_n[ra]), 32'(rv ? sh_v[ra] : sh_n[ra]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule

// File: doc/sap_store_unit.md
# sap_store_unit

Store-path sequencer for the SAP-1-style datapath: takes a single store request (address plus data byte, normally the accumulator) and drives the MAR and the RAM write port to commit it, with optional read-back verify. It is the write-side counterpart of the RAM-to-A load path. It sits between the control sequencer, which issues the request, and the MAR/RAM pair, which it drives directly.

## Interface
- `ADDR_W`, 4: address width; matches MAR and RAM depth of 16.
- `DATA_W`, 8: data width; matches the RAM word.
- `VERIFY`, 1: when 1, read back the written word and compare it.
- `PROG_TOP`, 7: highest address of the program region; stores to addresses 0..PROG_TOP are refused while `wp`=1.

- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `st_valid` in 1: store request valid.
- `st_ready` out 1: unit can accept a request.
- `st_addr` in ADDR_W: target address.
- `st_data` in DATA_W: word to store.
- `wp` in 1: write-protect for the program region; sampled at acceptance.
- `Lm` out 1: MAR load strobe.
- `mar_addr` out ADDR_W: address presented to the MAR.
- `We` out 1: RAM write enable.
- `ram_wdata` out DATA_W: RAM write data.
- `Ce` out 1: RAM read enable, used for verify.
- `ram_rdata` in DATA_W: RAM registered read data, valid the cycle after `Ce`.
- `busy` out 1: high whenever the state is not IDLE.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: sticky error flag; cleared by reset or by the next acceptance.

## Operation
- States: IDLE, ADDR, WRITE, READ, CHECK, DONE.
- IDLE:
  - `st_ready`=1.
  - Acceptance is `st_valid & st_ready` at a rising edge.
  - On acceptance: latch `st_addr`, `st_data` and `wp`; clear `err`.
- Acceptance transitions:
  - Latched `wp`=1 and addr ≤ PROG_TOP (refused store): go to DONE and set `err`=1. No `Lm`, `We` or `Ce` is asserted.
  - Otherwise: go to ADDR.
- ADDR: `Lm`=1 and `mar_addr`=latched address. Next state is WRITE.
- WRITE: `We`=1 and `ram_wdata`=latched data. Next state is READ if VERIFY=1, otherwise DONE.
- READ: `Ce`=1. Next state is CHECK.
- CHECK: compare `ram_rdata` with the latched data. On mismatch set `err`=1. Next state is DONE.
- DONE: `done`=1. Next state is IDLE.
- Outputs are decoded from the state only (Moore).
  - `mar_addr` and `ram_wdata` hold the latched values in every state.
  - In IDLE they hold the last latched values; they are 0 after reset.
- Arithmetic: the comparison is a full DATA_W equality. Address compare is unsigned. No wrap: addresses are only passed through, never incremented.

## Timing
- Reset values: IDLE, `st_ready`=1, and `Lm`=`We`=`Ce`=`busy`=`done`=`err`=0. `mar_addr` and `ram_wdata` are 0.
- Latency from the accepting edge to the `done` high cycle:
  - VERIFY=0: 3 cycles.
  - VERIFY=1: 5 cycles.
  - Refused store: 1 cycle.
- Throughput: one store every 4 cycles (VERIFY=0) or 6 cycles (VERIFY=1). `st_ready` is low from ADDR through DONE.
- A request held on `st_valid` while `st_ready`=0 is not lost. It is accepted at the first edge in IDLE.
- `err` stays set through IDLE until reset or the next acceptance. `err` and `done` are high together in DONE.
- Reset mid-operation: the next edge forces IDLE and all strobes go low.
  - A word already written with `We` high is not undone.
  - No `done` pulse is produced for the aborted request.
- Reset and `st_valid` asserted together: reset wins and nothing is accepted.

## Structure
- Shared package `sap_pkg` holds:
  - the `ADDR_W`/`DATA_W` defaults;
  - the `store_state_t` enum (IDLE..DONE);
  - the `PROG_TOP` default.
- The block is a single module. The FSM, latches and comparator are small, so no sub-module is needed.

## Test plan
- Reset, then a store of addr=4'hA, data=8'h3C with `wp`=0 and VERIFY=1:
  - `Lm` is high 1 cycle after accept with `mar_addr`=A.
  - `We` is high at +2 with `ram_wdata`=3C.
  - `Ce` is high at +3.
  - `done` is high at +5 with `err`=0; RAM[A] reads back 3C.
- Store to addr=4'h3 with `wp`=1: `done` and `err` are high 1 cycle after accept, and `Lm`/`We`/`Ce` never assert.
- Same store with `wp`=0: accepted, and `err`=0.
- Verify mismatch, with the RAM model forcing `ram_rdata`=8'h00 while 8'hFF is written: `err`=1 in DONE. `err` then stays 1 until the next acceptance clears it.
- Back-to-back requests with `st_valid` held high and VERIFY=0: acceptances occur exactly 4 cycles apart. Two stores (5→8'h11, 6→8'h22) both land in RAM.
- `reset` pulsed in the WRITE state:
  - Next cycle is IDLE with all strobes 0 and `st_ready`=1.
  - No `done` pulse appears.
  - A following store completes normally.
